// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit order, hex glyph table and
// receive-decoder FSM states.
package seg7_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;
    localparam int unsigned SEG_W = SEG_G + 1;

    localparam int unsigned GLYPH_COUNT = 16;

    // Entry i is the active-high segment pattern that displays hex digit i.
    localparam logic [GLYPH_COUNT-1:0][SEG_W-1:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

endpackage

// File: rtl/seg7_glyph_lookup.sv
// Combinational reverse lookup of a seven-segment pattern to its hex digit.
// Patterns outside the glyph table report known_o=0, code_o=0.
module seg7_glyph_lookup
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern_i,
    output logic             known_o,
    output logic [3:0]       code_o
);

    always_comb begin
        known_o = 1'b0;
        code_o  = '0;
        for (int unsigned i = 0; i < GLYPH_COUNT; i++) begin
            if (pattern_i == GLYPH_TABLE[i[3:0]]) begin
                known_o = 1'b1;
                code_o  = i[3:0];
            end
        end
    end

endmodule

// File: rtl/seg7_rx_decoder.sv
// Seven-segment receive decoder: synchronizes the segment bus, accepts stable
// patterns and decodes them. Period measurement is built when SEG7_RX_PERIOD_EN is defined.
module seg7_rx_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned STABLE_W      = 5,
    parameter int unsigned PERIOD_W      = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEG_W-1:0]    seg_in,
    output logic [SEG_W-1:0]    pattern,
    output logic [3:0]          code,
    output logic                known,
    output logic                blank,
    output logic                code_valid,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    localparam logic [STABLE_W-1:0] STAB_ONE  = STABLE_W'(1);
    localparam logic [STABLE_W-1:0] STAB_LAST = STABLE_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0]    sync1_q;
    logic [SEG_W-1:0]    s_q;

    rx_state_e           state_q, state_d;
    logic [SEG_W-1:0]    cand_q, cand_d;
    logic [STABLE_W-1:0] stab_q, stab_d;
    logic [SEG_W-1:0]    pattern_q, pattern_d;
    logic [3:0]          code_q, code_d;
    logic                known_q, known_d;
    logic                blank_q, blank_d;
    logic                cv_q, cv_d;
    logic                reported_q, reported_d;

    logic                lk_known;
    logic [3:0]          lk_code;

    seg7_glyph_lookup u_lookup (
        .pattern_i (cand_q),
        .known_o   (lk_known),
        .code_o    (lk_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            s_q     <= '0;
        end else begin
            sync1_q <= seg_in;
            s_q     <= sync1_q;
        end
    end

    // The sample that loads the candidate counts as the first stable sample,
    // so acceptance happens on the sample where stab_q already holds STABLE_CYCLES-1.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        stab_d     = stab_q;
        pattern_d  = pattern_q;
        code_d     = code_q;
        known_d    = known_q;
        blank_d    = blank_q;
        cv_d       = 1'b0;
        reported_d = reported_q;

        case (state_q)
            IDLE: begin
                cand_d  = s_q;
                stab_d  = STAB_ONE;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (s_q != cand_q) begin
                    cand_d = s_q;
                    stab_d = STAB_ONE;
                end else if (stab_q == STAB_LAST) begin
                    state_d = LOCKED;
                    if (!reported_q || (cand_q != pattern_q)) begin
                        pattern_d  = cand_q;
                        code_d     = lk_code;
                        known_d    = lk_known;
                        blank_d    = (cand_q == '0);
                        cv_d       = 1'b1;
                        reported_d = 1'b1;
                    end
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            LOCKED: begin
                if (s_q != pattern_q) begin
                    cand_d  = s_q;
                    stab_d  = STAB_ONE;
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            stab_q     <= '0;
            pattern_q  <= '0;
            code_q     <= '0;
            known_q    <= 1'b0;
            blank_q    <= 1'b1;
            cv_q       <= 1'b0;
            reported_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            stab_q     <= stab_d;
            pattern_q  <= pattern_d;
            code_q     <= code_d;
            known_q    <= known_d;
            blank_q    <= blank_d;
            cv_q       <= cv_d;
            reported_q <= reported_d;
        end
    end

    assign pattern    = pattern_q;
    assign code       = code_q;
    assign known      = known_q;
    assign blank      = blank_q;
    assign code_valid = cv_q;

`ifdef SEG7_RX_PERIOD_EN
    localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;

    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                pv_q, pv_d;

    // pcnt counts edges since the last pulse minus one, hence the +1 on report.
    always_comb begin
        pcnt_d   = (pcnt_q == PCNT_MAX) ? pcnt_q : pcnt_q + 1'b1;
        period_d = period_q;
        pv_d     = 1'b0;
        if (cv_d) begin
            pcnt_d = '0;
            if (reported_q) begin
                period_d = (pcnt_q == PCNT_MAX) ? PCNT_MAX : pcnt_q + 1'b1;
                pv_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Self-checking bench for seg7_rx_decoder: directed sequences, a glyph vector
// table and randomized segment streams against a run-length reference model.
module tb_seg7_rx_decoder;

    localparam int STABLE = 16;

`ifdef SEG7_RX_PERIOD_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;

    logic [6:0]  pattern, pattern8;
    logic [3:0]  code, code8;
    logic        known, known8, blank, blank8;
    logic        code_valid, code_valid8;
    logic [23:0] period;
    logic [7:0]  period8;
    logic        period_valid, period_valid8;

    always #50 clk = ~clk;

    seg7_rx_decoder #(.STABLE_CYCLES(STABLE), .STABLE_W(5), .PERIOD_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in),
        .pattern(pattern), .code(code), .known(known), .blank(blank),
        .code_valid(code_valid), .period(period), .period_valid(period_valid)
    );

    seg7_rx_decoder #(.STABLE_CYCLES(STABLE), .STABLE_W(5), .PERIOD_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in),
        .pattern(pattern8), .code(code8), .known(known8), .blank(blank8),
        .code_valid(code_valid8), .period(period8), .period_valid(period_valid8)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic void ref_decode(input logic [6:0] p, output logic k, output logic [3:0] c);
        k = 1'b0;
        c = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (glyph_tab[i] == p) begin
                k = 1'b1;
                c = 4'(i);
            end
        end
    endfunction

    // Reference: a value is accepted when the synchronized stream has shown it
    // for exactly STABLE consecutive samples; reported if new or first since reset.
    logic [6:0]  m_d1, m_d2, m_now, m_runval;
    int          m_run, m_since;
    bit          m_seen;
    logic [6:0]  e_pat;
    logic [3:0]  e_code;
    logic        e_known, e_blank, e_cv, e_pv;
    logic [23:0] e_per;
    logic [7:0]  e_per8;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = '0; m_d2 = '0; m_runval = '0; m_run = 0; m_since = 0; m_seen = 1'b0;
            e_pat = '0; e_code = '0; e_known = 1'b0; e_blank = 1'b1;
            e_cv = 1'b0; e_pv = 1'b0; e_per = '0; e_per8 = '0;
        end else begin
            m_now = m_d2;
            m_d2  = m_d1;
            m_d1  = seg_in;
            if (m_run != 0 && m_now == m_runval) m_run++;
            else begin
                m_runval = m_now;
                m_run    = 1;
            end
            m_since++;
            e_cv = 1'b0;
            e_pv = 1'b0;
            if (m_run == STABLE && (!m_seen || m_now != e_pat)) begin
                e_pat = m_now;
                ref_decode(m_now, e_known, e_code);
                e_blank = (m_now == 7'h00);
                e_cv = 1'b1;
                if (m_seen && PEN) begin
                    e_pv   = 1'b1;
                    e_per  = (m_since > 32'hFF_FFFF) ? 24'hFF_FFFF : 24'(m_since);
                    e_per8 = (m_since > 255) ? 8'hFF : 8'(m_since);
                end
                m_seen  = 1'b1;
                m_since = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("outs", {pattern, code, known, blank, code_valid, period_valid},
                      {e_pat, e_code, e_known, e_blank, e_cv, e_pv});
        check("period", 32'(period), 32'(e_per));
        check("outs8", {pattern8, code8, known8, blank8, code_valid8, period_valid8, period8},
                       {e_pat, e_code, e_known, e_blank, e_cv, e_pv, e_per8});
    end

    task automatic drive(input logic [6:0] v);
        #1 seg_in = v;
    endtask

    // Returns the negedge index k (after posedge k) at which code_valid is seen, or -1.
    task automatic wait_pulse(input int maxc, output int at);
        at = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (code_valid) begin
                at = k;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int ncyc, output int n);
        n = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (code_valid) n++;
        end
    endtask

    typedef struct packed {
        logic [6:0] seg;
        logic       known;
        logic [3:0] code;
        logic       blank;
    } vec_t;

    vec_t vecs [19];
    int   at, n;

    initial begin
        vecs[0]  = '{7'h3F, 1'b1, 4'h0, 1'b0};
        vecs[1]  = '{7'h06, 1'b1, 4'h1, 1'b0};
        vecs[2]  = '{7'h5B, 1'b1, 4'h2, 1'b0};
        vecs[3]  = '{7'h4F, 1'b1, 4'h3, 1'b0};
        vecs[4]  = '{7'h66, 1'b1, 4'h4, 1'b0};
        vecs[5]  = '{7'h6D, 1'b1, 4'h5, 1'b0};
        vecs[6]  = '{7'h7D, 1'b1, 4'h6, 1'b0};
        vecs[7]  = '{7'h07, 1'b1, 4'h7, 1'b0};
        vecs[8]  = '{7'h7F, 1'b1, 4'h8, 1'b0};
        vecs[9]  = '{7'h6F, 1'b1, 4'h9, 1'b0};
        vecs[10] = '{7'h77, 1'b1, 4'hA, 1'b0};
        vecs[11] = '{7'h7C, 1'b1, 4'hB, 1'b0};
        vecs[12] = '{7'h39, 1'b1, 4'hC, 1'b0};
        vecs[13] = '{7'h5E, 1'b1, 4'hD, 1'b0};
        vecs[14] = '{7'h79, 1'b1, 4'hE, 1'b0};
        vecs[15] = '{7'h71, 1'b1, 4'hF, 1'b0};
        vecs[16] = '{7'h7E, 1'b0, 4'h0, 1'b0};
        vecs[17] = '{7'h00, 1'b0, 4'h0, 1'b1};
        vecs[18] = '{7'h40, 1'b0, 4'h0, 1'b0};

        seg_in = 7'h00;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pattern", 32'(pattern), 32'h00);
        check("rst_code", 32'(code), 32'h0);
        check("rst_known", 32'(known), 32'h0);
        check("rst_blank", 32'(blank), 32'h1);
        check("rst_cv", 32'(code_valid), 32'h0);
        check("rst_period", 32'(period), 32'h0);
        check("rst_pv", 32'(period_valid), 32'h0);

        // First report after reset at cycle 18.
        drive(7'h3F);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_pulse(40, at);
        check("first_latency", at, 18);
        check("first_code", 32'(code), 32'h0);
        check("first_known", 32'(known), 32'h1);
        check("first_blank", 32'(blank), 32'h0);
        check("first_pv", 32'(period_valid), 32'h0);
        count_pulses(40, n);
        check("first_single", n, 0);

        // 1000-cycle dwell gives period 1000 (saturated 255 at 8 bits).
        drive(7'h06);
        wait_pulse(40, at);
        check("step1_latency", at, 18);
        check("step1_code", 32'(code), 32'h1);
        check("step1_pv", 32'(period_valid), 32'h0 | 32'(PEN));
        repeat (1000 - 18) @(negedge clk);
        drive(7'h5B);
        wait_pulse(40, at);
        check("step2_latency", at, 18);
        check("step2_code", 32'(code), 32'h2);
        check("step2_period", 32'(period), PEN ? 32'd1000 : 32'd0);
        check("step2_pv", 32'(period_valid), 32'(PEN));
        check("step2_period8", 32'(period8), PEN ? 32'd255 : 32'd0);
        repeat (300 - 18) @(negedge clk);
        drive(7'h4F);
        wait_pulse(40, at);
        check("step3_code", 32'(code), 32'h3);
        check("step3_period", 32'(period), PEN ? 32'd300 : 32'd0);
        check("step3_period8", 32'(period8), PEN ? 32'd255 : 32'd0);
        check("step3_pv8", 32'(period_valid8), 32'(PEN));

        // Short glitch while locked is ignored.
        drive(7'h06);
        wait_pulse(40, at);
        check("pre_glitch", 32'(code), 32'h1);
        drive(7'h7F);
        repeat (3) @(negedge clk);
        drive(7'h06);
        count_pulses(60, n);
        check("glitch_nopulse", n, 0);
        check("glitch_pattern", 32'(pattern), 32'h06);

        // Unknown glyph, then blank.
        drive(7'h55);
        wait_pulse(20, at);
        check("unk_latency", at, 18);
        check("unk_known", 32'(known), 32'h0);
        check("unk_code", 32'(code), 32'h0);
        check("unk_pattern", 32'(pattern), 32'h55);
        check("unk_blank", 32'(blank), 32'h0);
        repeat (2) @(negedge clk);
        drive(7'h00);
        wait_pulse(40, at);
        check("blank_blank", 32'(blank), 32'h1);
        check("blank_known", 32'(known), 32'h0);
        check("blank_pattern", 32'(pattern), 32'h00);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].seg);
            wait_pulse(40, at);
            check("vec_latency", at, 18);
            check("vec_outs", {pattern, known, code, blank},
                  {vecs[i].seg, vecs[i].known, vecs[i].code, vecs[i].blank});
        end

        for (int i = 0; i < 250; i++) begin
            logic [6:0] v;
            int         d;
            v = ($urandom_range(0, 3) == 0) ? 7'($urandom) : glyph_tab[$urandom_range(0, 15)];
            d = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 60);
            drive(v);
            repeat (d) @(negedge clk);
        end

        // Reset while settling discards the candidate; reported afresh after release.
        drive(7'h06);
        repeat (40) @(negedge clk);
        drive(7'h3F);
        repeat (12) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cv", 32'(code_valid), 32'h0);
        check("midrst_pattern", 32'(pattern), 32'h00);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_pulse(40, at);
        check("midrst_latency", at, 18);
        check("midrst_code", 32'(code), 32'h0);
        check("midrst_pattern2", 32'(pattern), 32'h3F);
        check("midrst_pv", 32'(period_valid), 32'h0);

        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_pulse(40, at);
        check("rerst_latency", at, 18);
        check("rerst_code", 32'(code), 32'h0);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
